// File: rtl/apb_uart.sv
// APB completer UART, fixed 8N1 framing, small TX FIFO and programmable bit period.
// One wait state per APB transfer; PRDATA and PREADY are registered.
`timescale 1ns/1ps
module apb_uart #(
  parameter int unsigned TX_DEPTH    = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        tx,
  input  logic        rx
);

  localparam int unsigned AW = $clog2(TX_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  logic        r_pready;
  logic [31:0] r_prdata;
  logic [15:0] r_baud;

  logic [7:0]    r_fifo [TX_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;

  tx_state_e   r_tx_state;
  logic [15:0] r_tx_cnt, r_tx_div;
  logic [7:0]  r_tx_sh;
  logic [2:0]  r_tx_idx;
  logic        r_tx;

  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  rx_state_e   r_rx_state;
  logic [15:0] r_rx_cnt, r_rx_div;
  logic [7:0]  r_rx_sh, r_rx_byte;
  logic [2:0]  r_rx_idx;
  logic        r_rx_valid, r_rx_ovr, r_ferr, r_tx_ovf;

  logic        w_xfer, w_wr, w_rd;
  logic        w_sel_st, w_sel_tx, w_sel_rx, w_sel_bd;
  logic        w_empty, w_full, w_push, w_pop, w_tx_busy;
  logic [7:0]  w_head;
  logic        w_rx_fall, w_rx_store;
  logic [16:0] w_baud_p1;
  logic [15:0] w_half;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign PREADY = r_pready;
  assign PRDATA = r_prdata;
  assign tx     = r_tx;

  // The commit edge is the one that raises PREADY, so it can only fire once per transfer.
  assign w_xfer   = PSEL & PENABLE & ~r_pready;
  assign w_wr     = w_xfer & PWRITE;
  assign w_rd     = w_xfer & ~PWRITE;
  assign w_sel_st = (PADDR[3:2] == 2'd0);
  assign w_sel_tx = (PADDR[3:2] == 2'd1);
  assign w_sel_rx = (PADDR[3:2] == 2'd2);
  assign w_sel_bd = (PADDR[3:2] == 2'd3);
  assign w_unused = ^{PADDR[1:0], PWDATA[31:16]};

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[PW-1] != r_rptr[PW-1]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push    = w_wr & w_sel_tx & ~w_full;
  assign w_head    = r_fifo[r_rptr[AW-1:0]];
  assign w_pop     = ~w_empty & ((r_tx_state == TxIdle) |
                                 ((r_tx_state == TxStop) & (r_tx_cnt == 16'd0)));
  assign w_tx_busy = (r_tx_state != TxIdle) | ~w_empty;

  assign w_baud_p1  = {1'b0, r_baud} + 17'd1;
  assign w_half     = w_baud_p1[16:1];
  assign w_rx_fall  = r_rx_prev & ~r_rx_s2;
  assign w_rx_store = (r_rx_state == RxStop) & (r_rx_cnt == 16'd0);

  always_comb begin
    w_rdata = 32'd0;
    case (PADDR[3:2])
      2'd0:    w_rdata = {26'd0, r_tx_ovf, r_ferr, r_rx_ovr, r_rx_valid, w_full, w_tx_busy};
      2'd2:    w_rdata = {24'd0, r_rx_byte};
      2'd3:    w_rdata = {16'd0, r_baud};
      default: w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_pready <= 1'b0;
      r_prdata <= 32'd0;
      r_baud   <= DEFAULT_DIV;
    end else begin
      r_pready <= w_xfer;
      r_prdata <= w_rd ? w_rdata : 32'd0;
      if (w_wr && w_sel_bd) r_baud <= (PWDATA[15:0] == 16'd0) ? 16'd1 : PWDATA[15:0];
    end
  end

  always_ff @(posedge PCLK) begin
    if (w_push) r_fifo[r_wptr[AW-1:0]] <= PWDATA[7:0];
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  // A pop always starts a frame, either from idle or straight out of the stop bit.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_tx_state <= TxIdle;
      r_tx_cnt   <= 16'd0;
      r_tx_div   <= 16'd0;
      r_tx_sh    <= 8'd0;
      r_tx_idx   <= 3'd0;
      r_tx       <= 1'b1;
    end else if (w_pop) begin
      r_tx_state <= TxStart;
      r_tx_sh    <= w_head;
      r_tx_cnt   <= r_baud;
      r_tx_div   <= r_baud;
      r_tx       <= 1'b0;
    end else begin
      case (r_tx_state)
        TxStart: begin
          if (r_tx_cnt == 16'd0) begin
            r_tx_state <= TxData;
            r_tx_cnt   <= r_tx_div;
            r_tx_idx   <= 3'd0;
            r_tx       <= r_tx_sh[0];
          end else r_tx_cnt <= r_tx_cnt - 16'd1;
        end
        TxData: begin
          if (r_tx_cnt == 16'd0) begin
            r_tx_cnt <= r_tx_div;
            if (r_tx_idx == 3'd7) begin
              r_tx_state <= TxStop;
              r_tx       <= 1'b1;
            end else begin
              r_tx_idx <= r_tx_idx + 3'd1;
              r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
              r_tx     <= r_tx_sh[1];
            end
          end else r_tx_cnt <= r_tx_cnt - 16'd1;
        end
        TxStop: begin
          if (r_tx_cnt == 16'd0) r_tx_state <= TxIdle;
          else                   r_tx_cnt   <= r_tx_cnt - 16'd1;
        end
        default: r_tx_state <= TxIdle;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RxIdle;
      r_rx_cnt   <= 16'd0;
      r_rx_div   <= 16'd0;
      r_rx_sh    <= 8'd0;
      r_rx_idx   <= 3'd0;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      case (r_rx_state)
        RxIdle: begin
          if (w_rx_fall) begin
            r_rx_state <= RxStart;
            r_rx_div   <= r_baud;
            r_rx_cnt   <= w_half - 16'd1;
          end
        end
        RxStart: begin
          if (r_rx_cnt == 16'd0) begin
            r_rx_state <= r_rx_s2 ? RxIdle : RxData;
            r_rx_cnt   <= r_rx_div;
            r_rx_idx   <= 3'd0;
          end else r_rx_cnt <= r_rx_cnt - 16'd1;
        end
        RxData: begin
          if (r_rx_cnt == 16'd0) begin
            r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
            r_rx_cnt <= r_rx_div;
            if (r_rx_idx == 3'd7) r_rx_state <= RxStop;
            else                  r_rx_idx   <= r_rx_idx + 3'd1;
          end else r_rx_cnt <= r_rx_cnt - 16'd1;
        end
        RxStop: begin
          if (r_rx_cnt == 16'd0) r_rx_state <= RxIdle;
          else                   r_rx_cnt   <= r_rx_cnt - 16'd1;
        end
        default: r_rx_state <= RxIdle;
      endcase
    end
  end

  // A store beats a same-cycle RXDATA read; sticky sets beat a same-cycle STATUS read.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_rx_byte  <= 8'd0;
      r_rx_valid <= 1'b0;
      r_rx_ovr   <= 1'b0;
      r_ferr     <= 1'b0;
      r_tx_ovf   <= 1'b0;
    end else begin
      if (w_rx_store)               r_rx_byte  <= r_rx_sh;
      if (w_rx_store)               r_rx_valid <= 1'b1;
      else if (w_rd && w_sel_rx)    r_rx_valid <= 1'b0;
      if (w_rx_store && r_rx_valid) r_rx_ovr   <= 1'b1;
      else if (w_rd && w_sel_st)    r_rx_ovr   <= 1'b0;
      if (w_rx_store && !r_rx_s2)   r_ferr     <= 1'b1;
      else if (w_rd && w_sel_st)    r_ferr     <= 1'b0;
      if (w_wr && w_sel_tx && w_full) r_tx_ovf <= 1'b1;
      else if (w_rd && w_sel_st)      r_tx_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_uart.sv
// Directed bench for apb_uart: APB handshake, TX serial stream, RX frames and status flags.
// A queue of expected per-cycle tx levels is checked every cycle while a frame is due.
`timescale 1ns/1ps
module tb_apb_uart;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b0;
  logic [3:0]  PADDR = 4'h0;
  logic [31:0] PWDATA = 32'd0;
  logic        PWRITE = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PSEL = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        tx;
  logic        rx = 1'b1;

  localparam logic [3:0] A_ST = 4'h0, A_TX = 4'h4, A_RX = 4'h8, A_BD = 4'hC;

  int checks = 0;
  int failures = 0;

  // Expected tx level per cycle, consumed once the frame's start bit appears.
  logic exp_q[$];
  bit   aligned = 1'b0;
  int   align_wait = 0;

  // Behavioural view of the RX-side and overflow flags.
  logic       m_rx_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0, m_txovf = 1'b0;
  logic [7:0] m_rx_byte = 8'd0;

  logic [31:0] rd;

  apb_uart dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PENABLE (PENABLE),
    .PSEL    (PSEL),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .tx      (tx),
    .rx      (rx)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge PCLK) begin
    if (PRESET && exp_q.size() > 0) begin
      if (!aligned) begin
        if (tx === 1'b0) begin
          aligned = 1'b1;
          align_wait = 0;
        end else begin
          align_wait++;
          if (align_wait > 200) begin
            checks++;
            failures++;
            $display("FAIL tx_start_timeout: got no start bit, expected one within 200 cycles");
            exp_q.delete();
            align_wait = 0;
          end
        end
      end
      if (aligned) begin
        checks++;
        if (tx !== exp_q[0]) begin
          failures++;
          $display("FAIL tx_stream: got %b expected %b (%0d cycles left)", tx, exp_q[0],
                   exp_q.size());
          exp_q.delete();
          aligned = 1'b0;
        end else begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) aligned = 1'b0;
        end
      end
    end
  end

  task automatic add_frame(input logic [7:0] b, input int div);
    for (int i = 0; i < 10; i++) begin
      logic v;
      v = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      repeat (div + 1) exp_q.push_back(v);
    end
  endtask

  task automatic apb(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata);
    int waits;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    chk("pready_access1", {31'd0, PREADY}, 32'd0);
    @(posedge PCLK); #1;
    waits = 0;
    while (PREADY !== 1'b1 && waits < 8) begin
      @(posedge PCLK); #1;
      waits++;
    end
    chk("pready_2nd_cycle_waits", waits, 32'd0);
    rdata = PRDATA;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    chk("pready_one_cycle", {31'd0, PREADY}, 32'd0);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    apb(1'b1, addr, data, dummy);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    apb(1'b0, addr, 32'd0, d);
    chk(name, d, exp);
  endtask

  task automatic rd_status(input string name, input logic busy, input logic full);
    rd_chk(name, A_ST, {26'd0, m_txovf, m_ferr, m_ovr, m_rx_valid, full, busy});
    m_txovf = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic rd_rx(input string name, output logic [31:0] d);
    apb(1'b0, A_RX, 32'd0, d);
    chk(name, d, {24'd0, m_rx_byte});
    m_rx_valid = 1'b0;
  endtask

  // Bit period of 4 cycles (BAUDDIV=3).
  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(posedge PCLK); #1;
    rx = 1'b0;
    repeat (4) @(posedge PCLK);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (4) @(posedge PCLK);
    end
    #1 rx = stop;
    repeat (4) @(posedge PCLK);
    #1 rx = 1'b1;
    if (m_rx_valid) m_ovr = 1'b1;
    m_rx_byte = b;
    m_rx_valid = 1'b1;
    if (!stop) m_ferr = 1'b1;
    repeat (6) @(posedge PCLK);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(posedge PCLK);
      n++;
    end
    chk(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [9:0] a5_bits;
    logic [31:0] d;
    a5_bits = 10'b1101001010;

    // Reset values.
    repeat (3) @(posedge PCLK);
    #1;
    chk("reset_pready", {31'd0, PREADY}, 32'd0);
    chk("reset_prdata", PRDATA, 32'd0);
    chk("reset_tx", {31'd0, tx}, 32'd1);
    @(negedge PCLK) PRESET = 1'b1;
    rd_status("status_after_reset", 1'b0, 1'b0);
    rd_chk("bauddiv_reset", A_BD, 32'd867);
    rd_chk("txdata_reads_zero", A_TX, 32'd0);

    // Reset in the middle of a frame and of an APB transfer.
    wr(A_BD, 32'd5);
    wr(A_TX, 32'h00);
    chk("tx_low_midframe", {31'd0, tx}, 32'd0);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = A_ST;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    chk("pready_before_reset", {31'd0, PREADY}, 32'd1);
    #2 PRESET = 1'b0;
    #1;
    chk("async_reset_tx", {31'd0, tx}, 32'd1);
    chk("async_reset_pready", {31'd0, PREADY}, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK) PRESET = 1'b1;
    rd_status("status_after_midreset", 1'b0, 1'b0);
    rd_chk("bauddiv_after_midreset", A_BD, 32'd867);
    chk("tx_idle_after_reset", {31'd0, tx}, 32'd1);

    // BAUDDIV boundary: 0 reads back as 1.
    wr(A_BD, 32'd0);
    rd_chk("bauddiv_zero_as_one", A_BD, 32'd1);
    wr(A_BD, 32'hFFFF_0003);
    rd_chk("bauddiv_three", A_BD, 32'd3);

    // Single frame 0xA5.
    add_frame(8'hA5, 3);
    wr(A_TX, 32'hA5);
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          repeat ((k == 0) ? 2 : 4) @(posedge PCLK);
          #1 chk($sformatf("a5_bit%0d", k), {31'd0, tx}, {31'd0, a5_bits[k]});
        end
      end
      begin
        repeat (6) @(posedge PCLK);
        rd_status("status_busy_a5", 1'b1, 1'b0);
      end
    join
    wait_drain("a5_drain");
    repeat (2) @(posedge PCLK);
    rd_status("status_idle_after_a5", 1'b0, 1'b0);

    // Six back-to-back writes: one shifts, four queue, one drops.
    for (int i = 1; i <= 5; i++) add_frame(8'(i), 3);
    for (int i = 1; i <= 6; i++) wr(A_TX, 32'(i));
    m_txovf = 1'b1;
    apb(1'b0, A_ST, 32'd0, d);
    chk("status_full_ovf", d, 32'h23);
    m_txovf = 1'b0;
    rd_status("status_ovf_cleared", 1'b1, 1'b1);
    wait_drain("burst_drain");
    repeat (2) @(posedge PCLK);
    rd_status("status_idle_after_burst", 1'b0, 1'b0);

    // Push lands on the same edge as the stop-to-start pop.
    add_frame(8'hC3, 3); add_frame(8'h5A, 3); add_frame(8'h0F, 3);
    add_frame(8'hF0, 3); add_frame(8'h99, 3); add_frame(8'h66, 3);
    wr(A_TX, 32'hC3);
    chk("tx_start_next_cycle", {31'd0, tx}, 32'd0);
    wr(A_TX, 32'h5A);
    repeat (33) @(posedge PCLK);
    wr(A_TX, 32'h0F);
    rd_status("status_after_collision", 1'b1, 1'b0);
    wr(A_TX, 32'hF0);
    wr(A_TX, 32'h99);
    wr(A_TX, 32'h66);
    rd_status("status_full_after_collision", 1'b1, 1'b1);
    wait_drain("collision_drain");
    repeat (2) @(posedge PCLK);
    rd_status("status_idle_after_collision", 1'b0, 1'b0);

    // RX single frame.
    send_rx(8'h3C, 1'b1);
    rd_status("status_rx_valid", 1'b0, 1'b0);
    rd_rx("rxdata_3c", d);
    chk("rxdata_3c_literal", d, 32'h0000_003C);
    rd_status("status_rx_consumed", 1'b0, 1'b0);

    // Overrun, then framing error.
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    apb(1'b0, A_ST, 32'd0, d);
    chk("status_overrun", d, 32'h0C);
    m_ovr = 1'b0;
    rd_rx("rxdata_22", d);
    send_rx(8'h55, 1'b0);
    rd_status("status_frame_err", 1'b0, 1'b0);
    rd_rx("rxdata_55", d);

    // Glitch on an idle line, then a good frame.
    @(posedge PCLK); #1 rx = 1'b0;
    @(posedge PCLK); #1 rx = 1'b1;
    repeat (10) @(posedge PCLK);
    rd_status("status_after_glitch", 1'b0, 1'b0);
    send_rx(8'h81, 1'b1);
    rd_rx("rxdata_81", d);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected one within 2 ms");
    $fatal(1);
  end

endmodule
